// File: rtl/wb_unit_pkg.sv
// Shared definitions for the writeback unit: load funct3 encodings,
// the zero register index and the load-queue entry layout.
package wb_unit_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // One outstanding load: where it goes and how to shape the returned word.
  typedef struct packed {
    logic [4:0] rd;
    logic [2:0] funct3;
    logic [1:0] offset;
  } ld_entry_t;

endpackage

// File: rtl/wb_unit_ld_fmt.sv
// Combinational load-data aligner/extender. Picks the addressed byte or
// halfword out of an aligned memory word and sign/zero-extends it.
// Halfwords are taken from the aligned half selected by offset[1].
module ld_fmt
  import wb_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] word,
  input  logic [2:0]      funct3,
  input  logic [1:0]      offset,
  output logic [XLEN-1:0] value,
  output logic            bad_funct3
);

  logic [XLEN-1:0] byte_shift;
  logic [XLEN-1:0] half_shift;
  logic [7:0]      lane_byte;
  logic [15:0]     lane_half;

  assign byte_shift = word >> {offset, 3'b000};
  assign half_shift = word >> {offset[1], 4'b0000};
  assign lane_byte  = byte_shift[7:0];
  assign lane_half  = half_shift[15:0];

  // Select width and extension from funct3; unknown encodings pass the word and flag it.
  always_comb begin
    value      = word;
    bad_funct3 = 1'b0;
    case (funct3)
      F3_LB:   value = {{(XLEN-8){lane_byte[7]}}, lane_byte};
      F3_LH:   value = {{(XLEN-16){lane_half[15]}}, lane_half};
      F3_LW:   value = word;
      F3_LBU:  value = {{(XLEN-8){1'b0}}, lane_byte};
      F3_LHU:  value = {{(XLEN-16){1'b0}}, lane_half};
      default: begin
        value      = word;
        bad_funct3 = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/wb_unit.sv
// Writeback unit: merges execute results and returning load data onto the
// single regfile write port. Loads have priority; an execute result that
// collides with a load response is parked in a one-entry skid and written
// on the next cycle without a load response. Also tracks outstanding loads
// and exports a per-register busy mask for hazard stalls.
module wb_unit
  import wb_unit_pkg::*;
#(
  parameter int LD_DEPTH = 2,
  parameter int XLEN     = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            ex_valid,
  output logic            ex_ready,
  input  logic [4:0]      ex_rd,
  input  logic [XLEN-1:0] ex_val,
  input  logic            ld_issue_valid,
  output logic            ld_issue_ready,
  input  logic [4:0]      ld_rd,
  input  logic [2:0]      ld_funct3,
  input  logic [1:0]      ld_offset,
  input  logic            mem_rsp_valid,
  input  logic [XLEN-1:0] mem_rsp_data,
  output logic [4:0]      rd_addr,
  output logic [XLEN-1:0] w_val,
  output logic [31:0]     busy,
  output logic            err
);

  localparam int PTR_W = $clog2(LD_DEPTH);

  // Load queue state: per-slot valid bits, payload array, ring pointers.
  ld_entry_t          q_mem [LD_DEPTH];
  logic [LD_DEPTH-1:0] q_valid_reg, q_valid_next;
  logic [PTR_W-1:0]   wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0]   rd_ptr_reg, rd_ptr_next;

  // Skid entry holding one execute result displaced by a load response.
  logic               skid_full_reg, skid_full_next;
  logic [4:0]         skid_rd_reg, skid_rd_next;
  logic [XLEN-1:0]    skid_val_reg, skid_val_next;

  // Registered regfile write port and sticky error.
  logic [4:0]         rd_addr_reg, rd_addr_next;
  logic [XLEN-1:0]    w_val_reg, w_val_next;
  logic               err_reg, err_next;

  logic               q_empty;
  logic               q_full;
  logic               push;
  logic               rsp_pop;
  logic               rsp_orphan;
  logic               ex_accept;
  ld_entry_t          head;
  ld_entry_t          new_entry;
  logic [XLEN-1:0]    fmt_val;
  logic               fmt_bad;
  logic [31:0]        entry_mask [LD_DEPTH];
  logic [31:0]        busy_acc;

  assign q_empty    = ~|q_valid_reg;
  assign q_full     = &q_valid_reg;
  assign push       = ld_issue_valid && !q_full;
  assign rsp_pop    = mem_rsp_valid && !q_empty;
  assign rsp_orphan = mem_rsp_valid && q_empty;
  assign ex_accept  = ex_valid && !skid_full_reg;

  assign head      = q_mem[rd_ptr_reg];
  assign new_entry = '{rd: ld_rd, funct3: ld_funct3, offset: ld_offset};

  assign ex_ready       = !skid_full_reg;
  assign ld_issue_ready = !q_full;
  assign rd_addr        = rd_addr_reg;
  assign w_val          = w_val_reg;
  assign err            = err_reg;

  ld_fmt #(
    .XLEN(XLEN)
  ) u_ld_fmt (
    .word       (mem_rsp_data),
    .funct3     (head.funct3),
    .offset     (head.offset),
    .value      (fmt_val),
    .bad_funct3 (fmt_bad)
  );

  // Queue bookkeeping: pop on a response, push on an accepted issue; both may happen together.
  always_comb begin
    q_valid_next = q_valid_reg;
    wr_ptr_next  = wr_ptr_reg;
    rd_ptr_next  = rd_ptr_reg;
    if (rsp_pop) begin
      q_valid_next[rd_ptr_reg] = 1'b0;
      rd_ptr_next              = rd_ptr_reg + PTR_W'(1);
    end
    if (push) begin
      q_valid_next[wr_ptr_reg] = 1'b1;
      wr_ptr_next              = wr_ptr_reg + PTR_W'(1);
    end
  end

  // Write-port arbitration: load response, then skid, then direct execute result.
  always_comb begin
    rd_addr_next   = REG_ZERO;
    w_val_next     = '0;
    skid_full_next = skid_full_reg;
    skid_rd_next   = skid_rd_reg;
    skid_val_next  = skid_val_reg;
    err_next       = err_reg | rsp_orphan;
    if (rsp_pop) begin
      rd_addr_next = head.rd;
      w_val_next   = fmt_val;
      err_next     = err_reg | fmt_bad;
      // ex_accept implies the skid is empty here, so capturing cannot overwrite.
      if (ex_accept) begin
        skid_full_next = 1'b1;
        skid_rd_next   = ex_rd;
        skid_val_next  = ex_val;
      end
    end else if (skid_full_reg) begin
      rd_addr_next   = skid_rd_reg;
      w_val_next     = skid_val_reg;
      skid_full_next = 1'b0;
    end else if (ex_accept) begin
      rd_addr_next = ex_rd;
      w_val_next   = ex_val;
    end
  end

  // Per-slot one-hot destination mask, gated by slot validity.
  generate
    for (genvar gi = 0; gi < LD_DEPTH; gi++) begin : g_busy
      assign entry_mask[gi] = q_valid_reg[gi] ? (32'd1 << q_mem[gi].rd) : 32'd0;
    end
  endgenerate

  // OR the slot masks together; x0 is never reported busy.
  always_comb begin
    busy_acc = '0;
    for (int i = 0; i < LD_DEPTH; i++) begin
      busy_acc = busy_acc | entry_mask[i];
    end
  end

  assign busy = {busy_acc[31:1], 1'b0};

  // Queue payload needs no reset; validity bits decide what is meaningful.
  always_ff @(posedge clock) begin
    if (push) begin
      q_mem[wr_ptr_reg] <= new_entry;
    end
  end

  // Control state and the registered write port, cleared asynchronously.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      q_valid_reg   <= '0;
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      skid_full_reg <= 1'b0;
      skid_rd_reg   <= REG_ZERO;
      skid_val_reg  <= '0;
      rd_addr_reg   <= REG_ZERO;
      w_val_reg     <= '0;
      err_reg       <= 1'b0;
    end else begin
      q_valid_reg   <= q_valid_next;
      wr_ptr_reg    <= wr_ptr_next;
      rd_ptr_reg    <= rd_ptr_next;
      skid_full_reg <= skid_full_next;
      skid_rd_reg   <= skid_rd_next;
      skid_val_reg  <= skid_val_next;
      rd_addr_reg   <= rd_addr_next;
      w_val_reg     <= w_val_next;
      err_reg       <= err_next;
    end
  end

endmodule

// File: tb/tb_wb_unit.sv
// Directed bench for wb_unit: execute path, load formatting, skid collision,
// queue full / busy tracking, orphan responses and asynchronous reset.
module tb_wb_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        ex_valid;
  logic        ex_ready;
  logic [4:0]  ex_rd;
  logic [31:0] ex_val;
  logic        ld_issue_valid;
  logic        ld_issue_ready;
  logic [4:0]  ld_rd;
  logic [2:0]  ld_funct3;
  logic [1:0]  ld_offset;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic [4:0]  rd_addr;
  logic [31:0] w_val;
  logic [31:0] busy;
  logic        err;

  int errors = 0;
  int checks = 0;

  wb_unit #(
    .LD_DEPTH(2),
    .XLEN(32)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .ex_valid       (ex_valid),
    .ex_ready       (ex_ready),
    .ex_rd          (ex_rd),
    .ex_val         (ex_val),
    .ld_issue_valid (ld_issue_valid),
    .ld_issue_ready (ld_issue_ready),
    .ld_rd          (ld_rd),
    .ld_funct3      (ld_funct3),
    .ld_offset      (ld_offset),
    .mem_rsp_valid  (mem_rsp_valid),
    .mem_rsp_data   (mem_rsp_data),
    .rd_addr        (rd_addr),
    .w_val          (w_val),
    .busy           (busy),
    .err            (err)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Issue one load, wait a cycle, return the word, then check the formatted write.
  task automatic do_load(input string tag, input logic [4:0] rd, input logic [2:0] f3,
                         input logic [1:0] off, input logic [31:0] data,
                         input logic [31:0] exp_val);
    ld_issue_valid = 1'b1;
    ld_rd          = rd;
    ld_funct3      = f3;
    ld_offset      = off;
    tick();
    ld_issue_valid = 1'b0;
    check({tag, "_busy"}, busy, 32'd1 << rd);
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = data;
    tick();
    mem_rsp_valid = 1'b0;
    check({tag, "_rd"}, {27'd0, rd_addr}, {27'd0, rd});
    check({tag, "_val"}, w_val, exp_val);
    check({tag, "_busy_clr"}, busy, 32'd0);
    $display("load %s rd=%0d f3=%0d off=%0d data=%08h -> w_val=%08h", tag, rd, f3, off, data, w_val);
  endtask

  initial begin
    reset          = 1'b1;
    ex_valid       = 1'b0;
    ex_rd          = 5'd0;
    ex_val         = 32'd0;
    ld_issue_valid = 1'b0;
    ld_rd          = 5'd0;
    ld_funct3      = 3'd0;
    ld_offset      = 2'd0;
    mem_rsp_valid  = 1'b0;
    mem_rsp_data   = 32'd0;

    // Reset values, during and after reset.
    tick();
    tick();
    check("rst_rd_addr", {27'd0, rd_addr}, 32'd0);
    check("rst_w_val", w_val, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_busy", busy, 32'd0);
    check("rst_ex_ready", {31'd0, ex_ready}, 32'd1);
    check("rst_ld_ready", {31'd0, ld_issue_ready}, 32'd1);
    reset = 1'b0;
    tick();
    check("post_rst_rd_addr", {27'd0, rd_addr}, 32'd0);
    check("post_rst_ex_ready", {31'd0, ex_ready}, 32'd1);

    // Plain execute result: one-cycle latency, then idle.
    ex_valid = 1'b1;
    ex_rd    = 5'd5;
    ex_val   = 32'h0000_1234;
    tick();
    ex_valid = 1'b0;
    check("ex_rd_addr", {27'd0, rd_addr}, 32'd5);
    check("ex_w_val", w_val, 32'h0000_1234);
    $display("exec rd=5 val=00001234 -> rd_addr=%0d w_val=%08h", rd_addr, w_val);
    tick();
    check("ex_idle_rd", {27'd0, rd_addr}, 32'd0);
    check("ex_idle_val", w_val, 32'd0);

    // Load formatting.
    do_load("lb",  5'd7, 3'b000, 2'd2, 32'h80FF_0000, 32'hFFFF_FFFF);
    do_load("lbu", 5'd7, 3'b100, 2'd2, 32'h80FF_0000, 32'h0000_00FF);
    do_load("lh",  5'd7, 3'b001, 2'd2, 32'h8001_0000, 32'hFFFF_8001);
    do_load("lhu", 5'd8, 3'b101, 2'd0, 32'h8001_F00D, 32'h0000_F00D);
    do_load("lb0", 5'd2, 3'b000, 2'd3, 32'h7F00_0000, 32'h0000_007F);

    // Load response collides with an execute result: skid holds it for one cycle.
    ld_issue_valid = 1'b1;
    ld_rd          = 5'd4;
    ld_funct3      = 3'b010;
    ld_offset      = 2'd0;
    tick();
    ld_issue_valid = 1'b0;
    mem_rsp_valid  = 1'b1;
    mem_rsp_data   = 32'hDEAD_BEEF;
    ex_valid       = 1'b1;
    ex_rd          = 5'd3;
    ex_val         = 32'h0000_00AA;
    check("skid_pre_ready", {31'd0, ex_ready}, 32'd1);
    tick();
    mem_rsp_valid = 1'b0;
    ex_valid      = 1'b0;
    check("skid_ld_rd", {27'd0, rd_addr}, 32'd4);
    check("skid_ld_val", w_val, 32'hDEAD_BEEF);
    check("skid_ready_low", {31'd0, ex_ready}, 32'd0);
    tick();
    check("skid_ex_rd", {27'd0, rd_addr}, 32'd3);
    check("skid_ex_val", w_val, 32'h0000_00AA);
    check("skid_ready_back", {31'd0, ex_ready}, 32'd1);
    $display("skid: load x4 then exec x3=%08h", w_val);
    tick();
    check("skid_idle", {27'd0, rd_addr}, 32'd0);

    // Two loads to x9: queue fills, busy held until both retire.
    ld_issue_valid = 1'b1;
    ld_rd          = 5'd9;
    ld_funct3      = 3'b010;
    ld_offset      = 2'd0;
    tick();
    check("q1_ld_ready", {31'd0, ld_issue_ready}, 32'd1);
    tick();
    ld_issue_valid = 1'b0;
    check("q2_ld_ready", {31'd0, ld_issue_ready}, 32'd0);
    check("q2_busy", busy, 32'h0000_0200);
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'h0000_0011;
    tick();
    check("q_rsp1_rd", {27'd0, rd_addr}, 32'd9);
    check("q_rsp1_val", w_val, 32'h0000_0011);
    check("q_rsp1_busy", busy, 32'h0000_0200);
    check("q_rsp1_ld_ready", {31'd0, ld_issue_ready}, 32'd1);
    mem_rsp_data = 32'h0000_0022;
    tick();
    mem_rsp_valid = 1'b0;
    check("q_rsp2_val", w_val, 32'h0000_0022);
    check("q_rsp2_busy", busy, 32'd0);
    $display("queue: two loads to x9 retired, busy=%08h", busy);

    // Response with nothing outstanding: no write, sticky error.
    check("orphan_err_pre", {31'd0, err}, 32'd0);
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'h5555_5555;
    tick();
    mem_rsp_valid = 1'b0;
    check("orphan_rd", {27'd0, rd_addr}, 32'd0);
    check("orphan_err", {31'd0, err}, 32'd1);
    tick();
    tick();
    check("orphan_err_sticky", {31'd0, err}, 32'd1);
    $display("orphan response: rd_addr=%0d err=%0d", rd_addr, err);

    // Async reset with one load queued and the skid full.
    ld_issue_valid = 1'b1;
    ld_rd          = 5'd6;
    ld_funct3      = 3'b010;
    tick();
    ld_rd = 5'd10;
    tick();
    ld_issue_valid = 1'b0;
    mem_rsp_valid  = 1'b1;
    mem_rsp_data   = 32'h0000_0066;
    ex_valid       = 1'b1;
    ex_rd          = 5'd12;
    ex_val         = 32'h0000_0C0C;
    tick();
    mem_rsp_valid = 1'b0;
    ex_valid      = 1'b0;
    check("pre_rst_ex_ready", {31'd0, ex_ready}, 32'd0);
    check("pre_rst_busy", busy, 32'h0000_0400);
    check("pre_rst_rd", {27'd0, rd_addr}, 32'd6);
    reset = 1'b1;
    #1;
    check("arst_busy", busy, 32'd0);
    check("arst_rd_addr", {27'd0, rd_addr}, 32'd0);
    check("arst_ex_ready", {31'd0, ex_ready}, 32'd1);
    check("arst_err", {31'd0, err}, 32'd0);
    $display("async reset: busy=%08h rd_addr=%0d ex_ready=%0d", busy, rd_addr, ex_ready);
    tick();
    reset         = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'h0000_0010;
    tick();
    mem_rsp_valid = 1'b0;
    check("post_arst_rsp_rd", {27'd0, rd_addr}, 32'd0);
    check("post_arst_rsp_err", {31'd0, err}, 32'd1);
    tick();
    check("post_arst_idle", {27'd0, rd_addr}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
